// File: rtl/sqrt_disp_pkg.sv
// Shared constants for the square-root result display: FSM encoding,
// seven-segment patterns and the double-dabble digit adjust.
package sqrt_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam int NDIG = 3;

    // Patterns are {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Add 3 to every BCD digit >= 5 so the following left shift carries correctly
    function automatic logic [4*NDIG-1:0] dd_adjust(input logic [4*NDIG-1:0] w);
        logic [4*NDIG-1:0] r;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = (w[4*i +: 4] >= 4'd5) ? w[4*i +: 4] + 4'd3 : w[4*i +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to seven-segment pattern with a blanking override.
module seg7_decode
    import sqrt_disp_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_digit)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/sqrt_bcd_display.sv
// Accepts a binary result, converts it to BCD one bit per cycle and scans
// the last completed value onto a 3-digit multiplexed seven-segment display.
module sqrt_bcd_display
    import sqrt_disp_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int SCAN_DIV = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [11:0]       bcd,
    output logic              bcd_valid,
    output logic [6:0]        seg,
    output logic [2:0]        digit_sel
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

    state_t              r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [11:0]         r_work;
    logic [3:0]          r_bits;
    logic [11:0]         r_bcd;
    logic                r_shown;
    logic [CNT_W-1:0]    r_scan;
    logic [2:0]          r_digsel;

    logic [11:0]         w_adj;
    logic [DATA_W+11:0]  w_sh;
    logic [3:0]          w_digit;
    logic                w_blank;

    assign w_adj = dd_adjust(r_work);
    assign w_sh  = {w_adj, r_shift} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_work   <= '0;
            r_bits   <= '0;
            r_bcd    <= '0;
            r_shown  <= 1'b0;
            r_scan   <= '0;
            r_digsel <= 3'b000;
        end else begin
            case (r_state)
                IDLE, SHOW: begin
                    if (in_valid) begin
                        r_shift <= in_data;
                        r_work  <= '0;
                        r_bits  <= 4'(DATA_W);
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    r_work  <= w_sh[DATA_W+11:DATA_W];
                    r_shift <= w_sh[DATA_W-1:0];
                    r_bits  <= r_bits - 4'd1;
                    if (r_bits == 4'd1) begin
                        // whole result lands in one edge so the display never sees partial digits
                        r_bcd   <= w_sh[DATA_W+11:DATA_W];
                        r_state <= SHOW;
                        r_shown <= 1'b1;
                        if (!r_shown) r_digsel <= 3'b001;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // scan free-runs once anything has been shown; new results do not restart it
            if (r_shown) begin
                if (r_scan == SCAN_LAST) begin
                    r_scan   <= '0;
                    r_digsel <= {r_digsel[1:0], r_digsel[2]};
                end else begin
                    r_scan <= r_scan + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b1;
        if (r_digsel[0]) begin
            w_digit = r_bcd[3:0];
            w_blank = 1'b0;
        end else if (r_digsel[1]) begin
            w_digit = r_bcd[7:4];
            w_blank = (r_bcd[11:4] == 8'h00);
        end else if (r_digsel[2]) begin
            w_digit = r_bcd[11:8];
            w_blank = (r_bcd[11:8] == 4'h0);
        end
    end

    seg7_decode u_dec (
        .i_digit (w_digit),
        .i_blank (w_blank),
        .o_seg   (seg)
    );

    assign in_ready  = (r_state != CONV);
    assign bcd_valid = (r_state == SHOW);
    assign bcd       = r_bcd;
    assign digit_sel = r_digsel;

endmodule

// File: tb/tb_sqrt_bcd_display.sv
// Randomized and directed checks of sqrt_bcd_display against an arithmetic
// reference model of the BCD value and the scanned display.
module tb_sqrt_bcd_display;

    localparam int DATA_W   = 8;
    localparam int SCAN_DIV = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [11:0]       bcd;
    logic              bcd_valid;
    logic [6:0]        seg;
    logic [2:0]        digit_sel;

    int n_chk  = 0;
    int n_pass = 0;
    int last   = -1;   // last completed value, -1 when nothing shown since reset

    logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    sqrt_bcd_display #(.DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .seg       (seg),
        .digit_sel (digit_sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] ref_seg(input int v, input logic [2:0] sel);
        int h, t, u;
        if (v < 0) return 7'h00;
        h = v / 100; t = (v / 10) % 10; u = v % 10;
        case (sel)
            3'b001:  return PAT[u];
            3'b010:  return (h == 0 && t == 0) ? 7'h00 : PAT[t];
            3'b100:  return (h == 0) ? 7'h00 : PAT[h];
            default: return 7'h00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        int k = 0;
        while (!in_ready && k < 50) begin tick(); k++; end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
        in_data  = DATA_W'(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Accept v, then watch every cycle of the conversion. noise drives a
    // competing in_valid=7 during CONV that must be ignored.
    task automatic run(input int v, input bit noise);
        send(v);
        for (int k = 1; k <= DATA_W; k++) begin
            if (k < DATA_W) begin
                chk("conv_valid", 32'(bcd_valid), 32'd0);
                chk("conv_ready", 32'(in_ready), 32'd0);
                chk("conv_hold_bcd", 32'(bcd), (last < 0) ? 32'd0 : 32'(ref_bcd(last)));
                chk("conv_hold_seg", 32'(seg), 32'(ref_seg(last, digit_sel)));
                if (noise && k <= 4) begin
                    in_data  = 8'd7;
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            tick();
        end
        chk("done_valid", 32'(bcd_valid), 32'd1);
        chk("done_bcd", 32'(bcd), 32'(ref_bcd(v)));
        if (last < 0) chk("first_sel_units", 32'(digit_sel), 32'b001);
        last = v;
        chk("done_seg", 32'(seg), 32'(ref_seg(last, digit_sel)));
    endtask

    task automatic watch(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk("show_onehot", 32'($onehot(digit_sel)), 32'd1);
            chk("show_seg", 32'(seg), 32'(ref_seg(last, digit_sel)));
            chk("show_ready", 32'(in_ready), 32'd1);
            chk("show_valid", 32'(bcd_valid), 32'd1);
        end
    endtask

    // Each digit must be held exactly SCAN_DIV cycles and rotate units->tens->hundreds
    task automatic scan_order();
        logic [2:0] prev;
        int n;
        prev = digit_sel;
        n = 0;
        while (digit_sel == prev && n < SCAN_DIV + 2) begin tick(); n++; end
        chk("scan_change", 32'(digit_sel != prev), 32'd1);
        for (int s = 0; s < 3; s++) begin
            prev = digit_sel;
            n = 0;
            while (digit_sel == prev && n < SCAN_DIV + 2) begin
                chk("scan_seg", 32'(seg), 32'(ref_seg(last, digit_sel)));
                tick(); n++;
            end
            chk("scan_len", 32'(n), 32'(SCAN_DIV));
            chk("scan_rot", 32'(digit_sel), 32'({prev[1:0], prev[2]}));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_bcd"}, 32'(bcd), 32'd0);
        chk({tag, "_valid"}, 32'(bcd_valid), 32'd0);
        chk({tag, "_seg"}, 32'(seg), 32'd0);
        chk({tag, "_sel"}, 32'(digit_sel), 32'd0);
    endtask

    initial begin
        #2;
        chk_reset_outputs("rst");
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk_reset_outputs("idle");

        run(0, 1'b0);
        watch(3 * SCAN_DIV);

        run(255, 1'b0);
        scan_order();

        run(15, 1'b0);
        watch(3 * SCAN_DIV);

        run(100, 1'b1);
        watch(3 * SCAN_DIV);

        run(42, 1'b0);
        run(9, 1'b0);
        watch(3 * SCAN_DIV);

        for (int i = 0; i < 20; i++) begin
            int v, gap;
            v   = int'($urandom_range(0, 255));
            gap = int'($urandom_range(0, 2 * SCAN_DIV));
            watch(gap);
            run(v, 1'($urandom_range(0, 1)));
        end
        watch(SCAN_DIV);

        // Asynchronous reset in the middle of a conversion
        send(200);
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        tick(); tick();
        rst_n = 1'b1;
        last = -1;
        tick();
        chk_reset_outputs("post_rst");
        tick(); tick(); tick();
        chk_reset_outputs("post_rst_dark");
        run(73, 1'b0);
        watch(3 * SCAN_DIV);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sqrt_bcd_display.md
Name: sqrt_bcd_display

Overview:
Downstream consumer of the integer square-root stage.
- Accepts one binary result word (root or remainder) over a valid/ready handshake.
- Converts it to packed BCD with a sequential double-dabble (shift-add-3), one bit per cycle.
- Drives a 3-digit time-multiplexed seven-segment display from the last completed result, for the TinyTapeout dedicated outputs.

Parameters:
- DATA_W, 8, binary input width. Supported range 4..8; the digit count is fixed at 3 (NDIG localparam).
- SCAN_DIV, 1024, clock cycles each digit stays selected before the scan advances. Must be >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  DATA_W  binary value to convert (unsigned)
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block can accept in_data this cycle
- bcd  output  12  packed BCD of the last completed conversion: [11:8] hundreds, [7:4] tens, [3:0] units
- bcd_valid  output  1  bcd holds a completed result and no conversion is in flight
- seg  output  7  segment pattern, active high, bit order {g,f,e,d,c,b,a}
- digit_sel  output  3  one-hot digit enable: [0] units, [1] tens, [2] hundreds

Behaviour:
- Reset: asynchronous on rst_n low; outputs released on the first clk edge after rst_n rises.
  - Reset values: state=IDLE, in_ready=1, bcd=0x000, bcd_valid=0, seg=0, digit_sel=000, scan counter=0, shift/bit registers=0.
- States: IDLE, CONV, SHOW.
  - IDLE: in_ready=1, display dark (seg=0, digit_sel=000).
  - CONV: in_ready=0, bcd_valid=0.
  - SHOW: in_ready=1, bcd_valid=1.
- Handshake:
  - A transfer occurs on a clk edge where in_valid && in_ready. in_data is captured into the shift register, BCD work digits clear to 0, the bit counter loads DATA_W, and state goes to CONV.
  - in_valid while in_ready=0 is ignored and not queued; the upstream must hold it.
- Conversion: each CONV cycle performs, in order:
  - every work digit >= 5 gets +3;
  - the {digits, shift} register shifts left by 1;
  - the bit counter decrements.
  - Exactly DATA_W CONV cycles follow acceptance. On the edge ending the last one, bcd loads the work digits and state goes to SHOW.
  - Latency: accept on edge N, bcd_valid high after edge N+DATA_W (8 by default).
- Back-to-back transfer in SHOW is allowed:
  - state returns to CONV and bcd_valid drops;
  - bcd and the display keep the old value until the new conversion completes;
  - the new value appears atomically (no partial digits).
- Display (active whenever at least one result has completed since reset, including during later CONV):
  - Scan counter counts 0..SCAN_DIV-1 and wraps. On wrap, digit_sel rotates units -> tens -> hundreds -> units.
  - First digit after the first completion is units. The scan does not reset on new results.
  - seg is the decoded pattern of the selected digit.
  - Leading-zero blanking: hundreds blank (seg=0) if it is 0; tens blank if hundreds and tens are both 0; units never blank.
  - digit_sel stays asserted while its digit is blanked.
- Decoder patterns (gfedcba): 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. Codes 10..15 are unreachable and must drive 0x00.
- Mid-operation reset (rst_n low during CONV or SHOW): everything returns to reset values immediately. The partial conversion is discarded and the display goes dark.
- All arithmetic is unsigned. Digits are 4 bits; the add-3 cannot overflow because a digit is <= 9 before adjustment.

Decomposition:
- Shared package sqrt_disp_pkg holds:
  - the state encoding constants IDLE/CONV/SHOW (2 bits);
  - the ten seven-segment pattern constants;
  - SEG_BLANK = 7'h00.
- One natural sub-module, seg7_decode: combinational, 4-bit digit plus blank flag in, 7-bit seg out.
- The handshake, double-dabble, and scan logic stay in sqrt_bcd_display.

Test Plan:
- Reset, then in_data=0 with in_valid for one cycle:
  - bcd_valid rises exactly 8 cycles after accept, with bcd=0x000;
  - with units selected, seg=0x3F; tens and hundreds slots show seg=0x00.
- in_data=255: bcd=0x255; scanning shows 0x6D (units), 0x6D (tens), 0x5B (hundreds), each held SCAN_DIV cycles, in_ready=1 throughout SHOW.
- in_data=15 (max root of an 8-bit input): bcd=0x015; hundreds blank, tens=0x06, units=0x6D.
- Accept 100, and during CONV assert in_valid with 7:
  - the 7 is ignored (in_ready=0);
  - bcd=0x100 with tens shown as 0x3F, since a non-leading zero is not blanked.
- Back-to-back from SHOW: 42 then 9. bcd stays 0x042 until 8 cycles after the second accept, then becomes 0x009 in one step; bcd_valid is low in between.
- Reset mid-conversion: pulse rst_n low 3 cycles after accepting 200. All outputs drop to reset values asynchronously; after release, state is IDLE, bcd=0x000, and the display is dark.
